raster_block_packer: RTL and testbench

- Write-side feeder for the DRAM controller.
- Owns the render raster position (hcount/vcount) that drives the per-pixel shading logic (e.g. triangle fill) and samples the shaded colour each cycle.
- Packs consecutive pixels into one cache-block-sized word and presents it with its pixel-index address on a valid/ready write port.
- A one-entry output slot lets rasterisation continue while the previous block waits for the DRAM side.

---
 rtl/raster_block_packer.sv | 167 ++++++++++++++++
 tb/tb_raster_block_packer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_block_packer.sv
// rtl/raster_block_packer.sv - raster walker that packs shaded pixels into cache blocks for the DRAM write port
module raster_block_packer #(
  parameter int PIXEL_BITS   = 16,
  parameter int BLOCK_PIXELS = 256,
  parameter int FRAME_WIDTH  = 1024,
  parameter int FRAME_HEIGHT = 768,
  parameter int ADDR_BITS    = 27,
  parameter int H_BITS       = 11,
  parameter int V_BITS       = 11
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               run,
  output logic [H_BITS-1:0]                  hcount,
  output logic [V_BITS-1:0]                  vcount,
  input  logic [PIXEL_BITS-1:0]              pixel_in,
  output logic                               write_request,
  input  logic                               write_ready,
  output logic [ADDR_BITS-1:0]               write_address,
  output logic [BLOCK_PIXELS*PIXEL_BITS-1:0] write_data,
  output logic                               frame_done,
  output logic                               busy
);

  localparam int IDX_BITS  = (BLOCK_PIXELS > 1) ? $clog2(BLOCK_PIXELS) : 1;
  localparam int DATA_BITS = BLOCK_PIXELS * PIXEL_BITS;

  localparam logic [IDX_BITS-1:0]  IDX_LAST = IDX_BITS'(BLOCK_PIXELS - 1);
  localparam logic [H_BITS-1:0]    H_LAST   = H_BITS'(FRAME_WIDTH - 1);
  localparam logic [V_BITS-1:0]    V_LAST   = V_BITS'(FRAME_HEIGHT - 1);
  // Address of the final block of a frame; its acceptance marks frame completion.
  localparam logic [ADDR_BITS-1:0] LAST_BLOCK_ADDR =
    ADDR_BITS'((FRAME_HEIGHT - 1) * FRAME_WIDTH + FRAME_WIDTH - BLOCK_PIXELS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                 state_q;
  logic [H_BITS-1:0]      hcount_q, hcount_d;
  logic [V_BITS-1:0]      vcount_q, vcount_d;
  logic [IDX_BITS-1:0]    idx_q, idx_d;
  logic [DATA_BITS-1:0]   fill_q, fill_d;
  logic [ADDR_BITS-1:0]   start_addr_q, start_addr_d;
  logic                   wr_req_q, wr_req_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0]   wr_data_q, wr_data_d;
  logic                   frame_done_q, frame_done_d;

  logic                   xfer;
  logic                   last_idx;
  logic                   stall;
  logic                   adv;
  logic                   h_last;
  logic                   v_last;
  logic                   frame_end;
  logic [ADDR_BITS-1:0]   pos_addr;

  // Pixel index of the current raster position, evaluated at the address width.
  assign pos_addr = ADDR_BITS'(vcount_q) * ADDR_BITS'(FRAME_WIDTH) + ADDR_BITS'(hcount_q);

  // Datapath next-state: raster advance, block fill, output slot load and release.
  always_comb begin
    xfer      = wr_req_q && write_ready;
    last_idx  = (idx_q == IDX_LAST);
    // Only the completing pixel must wait; earlier pixels go into the fill buffer freely.
    stall     = last_idx && wr_req_q && !write_ready;
    adv       = (state_q == ST_RUN) && enable && !stall;
    h_last    = (hcount_q == H_LAST);
    v_last    = (vcount_q == V_LAST);
    frame_end = adv && h_last && v_last;

    hcount_d     = hcount_q;
    vcount_d     = vcount_q;
    idx_d        = idx_q;
    fill_d       = fill_q;
    start_addr_d = start_addr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_req_d     = xfer ? 1'b0 : wr_req_q;
    frame_done_d = xfer && (wr_addr_q == LAST_BLOCK_ADDR);

    if (adv) begin
      fill_d[idx_q*PIXEL_BITS +: PIXEL_BITS] = pixel_in;
      idx_d = idx_q + IDX_BITS'(1);

      if (h_last) begin
        hcount_d = '0;
        vcount_d = v_last ? '0 : vcount_q + V_BITS'(1);
      end else begin
        hcount_d = hcount_q + H_BITS'(1);
      end

      if (idx_q == '0) begin
        start_addr_d = pos_addr;
      end

      // The completing pixel bypasses the buffer register via fill_d, so a new
      // block can take the slot on the same edge the previous one is accepted.
      if (last_idx) begin
        wr_data_d = fill_d;
        wr_addr_d = (idx_q == '0) ? pos_addr : start_addr_q;
        wr_req_d  = 1'b1;
      end
    end
  end

  // Sequencer plus all registered state; reset discards any block held in the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hcount_q     <= '0;
      vcount_q     <= '0;
      idx_q        <= '0;
      fill_q       <= '0;
      start_addr_q <= '0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      idx_q        <= idx_d;
      fill_q       <= fill_d;
      start_addr_q <= start_addr_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;

      case (state_q)
        ST_IDLE: begin
          if (enable && run) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (frame_end) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Counters already wrapped to 0,0; wait until the last block has left.
          if (!wr_req_q) begin
            state_q <= run ? ST_RUN : ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign hcount        = hcount_q;
  assign vcount        = vcount_q;
  assign write_request = wr_req_q;
  assign write_address = wr_addr_q;
  assign write_data    = wr_data_q;
  assign frame_done    = frame_done_q;
  assign busy          = (state_q != ST_IDLE) || wr_req_q;

endmodule

// File: tb/tb_raster_block_packer.sv
// tb/tb_raster_block_packer.sv - scoreboard bench for raster_block_packer on a small frame
module tb_raster_block_packer;

  localparam int PB   = 16;
  localparam int BP   = 4;
  localparam int FW   = 8;
  localparam int FH   = 4;
  localparam int AB   = 27;
  localparam int HB   = 11;
  localparam int VB   = 11;
  localparam int DB   = BP * PB;
  localparam int NBLK = FW * FH / BP;
  localparam int LAST_ADDR = (FH - 1) * FW + FW - BP;
  localparam int BOUND = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          run;
  logic [HB-1:0] hcount;
  logic [VB-1:0] vcount;
  logic [PB-1:0] pixel_in;
  logic          write_request;
  logic          write_ready;
  logic [AB-1:0] write_address;
  logic [DB-1:0] write_data;
  logic          frame_done;
  logic          busy;

  logic [PB-1:0] salt;

  typedef struct {
    logic [AB-1:0] addr;
    logic [DB-1:0] data;
  } blk_t;

  blk_t sb[$];

  int  total = 0;
  int  bad = 0;
  int  fd_count = 0;
  bit  fd_pending = 1'b0;
  bit  rdy_rand = 1'b0;
  bit  en_rand = 1'b0;
  int  rdy_pct = 100;
  int  en_pct = 100;

  always #5 clk = ~clk;

  // Shading stand-in: colour is a pure function of the raster position and a salt.
  assign pixel_in = PB'({vcount, hcount}) ^ salt;

  raster_block_packer #(
    .PIXEL_BITS  (PB),
    .BLOCK_PIXELS(BP),
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH),
    .ADDR_BITS   (AB),
    .H_BITS      (HB),
    .V_BITS      (VB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .run          (run),
    .hcount       (hcount),
    .vcount       (vcount),
    .pixel_in     (pixel_in),
    .write_request(write_request),
    .write_ready  (write_ready),
    .write_address(write_address),
    .write_data   (write_data),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  function automatic logic [PB-1:0] pix_at(int p, logic [PB-1:0] s);
    int v;
    int h;
    v = p / FW;
    h = p % FW;
    return PB'((v << HB) | h) ^ s;
  endfunction

  task automatic check(string name, logic [DB-1:0] act, logic [DB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(string name);
    total++;
    bad++;
    $display("FAIL %s: bound of %0d cycles expired, want event", name, BOUND);
  endtask

  // Expected blocks of whole frames, in raster order, from the current salt.
  task automatic push_frames(int n);
    blk_t b;
    for (int f = 0; f < n; f++) begin
      for (int k = 0; k < NBLK; k++) begin
        b.addr = AB'(k * BP);
        b.data = '0;
        for (int j = 0; j < BP; j++) begin
          b.data[j*PB +: PB] = pix_at(k * BP + j, salt);
        end
        sb.push_back(b);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) write_ready = ($urandom_range(99) < rdy_pct);
    if (en_rand)  enable      = ($urandom_range(99) < en_pct);
  endtask

  // Let n started frames complete, dropping run during the last one.
  task automatic finish_frames(int n);
    int cnt;
    for (int f = 0; f < n; f++) begin
      cnt = 0;
      while (vcount != VB'(1) && cnt < BOUND) begin tick(); cnt++; end
      if (cnt >= BOUND) timeout_fail("mid_frame_wait");
      if (f == n - 1) run = 1'b0;
      cnt = 0;
      while (!frame_done && cnt < BOUND) begin tick(); cnt++; end
      if (cnt >= BOUND) timeout_fail("frame_done_wait");
    end
    cnt = 0;
    while (busy && cnt < BOUND) begin tick(); cnt++; end
    if (cnt >= BOUND) timeout_fail("idle_wait");
    check("idle_hcount", hcount, 0);
    check("idle_vcount", vcount, 0);
    check("idle_request", write_request, 0);
    check("sb_drained", sb.size(), 0);
  endtask

  // Monitor: every presented block is compared to the scoreboard head while held.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        fd_pending = 1'b0;
      end else begin
        if (fd_pending || frame_done) check("frame_done", frame_done, fd_pending);
        if (frame_done) fd_count++;
        fd_pending = 1'b0;
        if (write_request) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_block: got addr %0d want no request", write_address);
          end else begin
            check("blk_addr", write_address, sb[0].addr);
            check("blk_data", write_data, sb[0].data);
            if (write_ready) begin
              fd_pending = (sb[0].addr == AB'(LAST_ADDR));
              void'(sb.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fd0;
    rst = 1'b1;
    enable = 1'b0;
    run = 1'b0;
    write_ready = 1'b0;
    salt = '0;
    repeat (3) tick();
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_request", write_request, 0);
    check("rst_address", write_address, 0);
    check("rst_data", write_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Basic fill, two frames back to back, ready always high.
    push_frames(2);
    write_ready = 1'b1;
    run = 1'b1;
    enable = 1'b1;
    n = 0;
    while (!write_request && n < 50) begin tick(); n++; end
    check("first_req_latency", n, 5);
    check("first_blk_addr", write_address, 0);
    check("first_blk_data", write_data, 64'h0003_0002_0001_0000);
    finish_frames(2);

    // Backpressure: slot held, second block stalls on its last pixel.
    salt = 16'h5a3c;
    push_frames(1);
    write_ready = 1'b0;
    run = 1'b1;
    repeat (20) tick();
    check("bp_request", write_request, 1);
    check("bp_address", write_address, 0);
    check("bp_hcount", hcount, 7);
    check("bp_vcount", vcount, 0);
    write_ready = 1'b1;
    tick();
    check("bp_next_request", write_request, 1);
    check("bp_next_address", write_address, 4);
    finish_frames(1);

    // Ready arrives exactly on the cycle block 1 completes.
    salt = 16'h1234;
    push_frames(1);
    write_ready = 1'b0;
    run = 1'b1;
    n = 0;
    while (!(write_request && hcount == HB'(7) && vcount == '0) && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) timeout_fail("sim_load_wait");
    write_ready = 1'b1;
    tick();
    write_ready = 1'b0;
    check("sim_request", write_request, 1);
    check("sim_address", write_address, 4);
    check("sim_hcount", hcount, 0);
    check("sim_vcount", vcount, 1);
    write_ready = 1'b1;
    finish_frames(1);

    // Enable gating for three cycles at fill index 2.
    salt = 16'hbeef;
    push_frames(1);
    run = 1'b1;
    n = 0;
    while (!(hcount == HB'(2) && vcount == '0) && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) timeout_fail("gate_wait");
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gate_hcount", hcount, 2);
    end
    enable = 1'b1;
    finish_frames(1);

    // Stop mid-frame, stay idle, then restart from address 0.
    salt = 16'h0f0f;
    fd0 = fd_count;
    push_frames(1);
    run = 1'b1;
    finish_frames(1);
    check("stop_frame_done_count", fd_count - fd0, 1);
    repeat (5) tick();
    check("stop_busy", busy, 0);
    check("stop_hcount", hcount, 0);
    salt = 16'h7777;
    push_frames(1);
    run = 1'b1;
    finish_frames(1);

    // Reset while a block is pending: it must vanish.
    salt = 16'hc001;
    push_frames(1);
    write_ready = 1'b0;
    run = 1'b1;
    n = 0;
    while (!write_request && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) timeout_fail("rst_req_wait");
    rst = 1'b1;
    run = 1'b0;
    tick();
    check("rstreq_request", write_request, 0);
    check("rstreq_hcount", hcount, 0);
    check("rstreq_vcount", vcount, 0);
    check("rstreq_busy", busy, 0);
    rst = 1'b0;
    sb.delete();
    push_frames(1);
    write_ready = 1'b1;
    run = 1'b1;
    finish_frames(1);

    // Randomised ready and enable over several frames.
    for (int r = 0; r < 4; r++) begin
      salt = PB'($urandom);
      rdy_pct = $urandom_range(30, 90);
      en_pct = $urandom_range(60, 95);
      rdy_rand = 1'b1;
      en_rand = 1'b1;
      push_frames(1 + r % 2);
      run = 1'b1;
      finish_frames(1 + r % 2);
    end
    rdy_rand = 1'b0;
    en_rand = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
